// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM transmit chain: modulation encodings,
// Q1.15 constellation level constants, and the mapper FSM state type.
// Purely declarative; no latency or backpressure of its own.
package ofdm_pkg;

  // Modulation select encodings (2'b11 is treated as QPSK by consumers)
  localparam logic [1:0] MOD_QPSK  = 2'b00;
  localparam logic [1:0] MOD_16QAM = 2'b01;
  localparam logic [1:0] MOD_64QAM = 2'b10;

  // Per-axis amplitudes, already scaled into Q1.15 (level * unit A)
  localparam logic signed [15:0] QPSK_A   = 16'sh5A82;
  localparam logic signed [15:0] QAM16_L1 = 16'sh2AAA;
  localparam logic signed [15:0] QAM16_L3 = 16'sh7FFE;
  localparam logic signed [15:0] QAM64_L1 = 16'sh1249;
  localparam logic signed [15:0] QAM64_L3 = 16'sh36DB;
  localparam logic signed [15:0] QAM64_L5 = 16'sh5B6D;
  localparam logic signed [15:0] QAM64_L7 = 16'sh7FFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CLOSE = 2'd3
  } state_t;

  // Bits consumed per complex symbol for a given modulation
  function automatic logic [6:0] bits_per_sym(input logic [1:0] mode);
    case (mode)
      MOD_16QAM: return 7'd4;
      MOD_64QAM: return 7'd6;
      default:   return 7'd2;
    endcase
  endfunction

endpackage

// File: rtl/gray_level_lut.sv
// Gray-coded axis bits -> signed Q1.15 level for QPSK / 16-QAM / 64-QAM.
// Latency: combinational. Backpressure: none (pure lookup).
// Ports: i_mod  modulation select
//        i_bits axis bits, right-aligned, first serial bit is the MSB
//        o_level signed Q1.15 amplitude for this axis
module gray_level_lut
  import ofdm_pkg::*;
(
  input  logic [1:0]        i_mod,
  input  logic [2:0]        i_bits,
  output logic signed [15:0] o_level
);

  always_comb begin
    o_level = QPSK_A;
    case (i_mod)
      MOD_16QAM: begin
        case (i_bits[1:0])
          2'b00:   o_level = -QAM16_L3;
          2'b01:   o_level = -QAM16_L1;
          2'b11:   o_level =  QAM16_L1;
          default: o_level =  QAM16_L3;
        endcase
      end
      MOD_64QAM: begin
        case (i_bits)
          3'b000:  o_level = -QAM64_L7;
          3'b001:  o_level = -QAM64_L5;
          3'b011:  o_level = -QAM64_L3;
          3'b010:  o_level = -QAM64_L1;
          3'b110:  o_level =  QAM64_L1;
          3'b111:  o_level =  QAM64_L3;
          3'b101:  o_level =  QAM64_L5;
          default: o_level =  QAM64_L7;
        endcase
      end
      // QPSK and the spare encoding: a single bit per axis, 0 -> +A
      default: o_level = i_bits[0] ? -QPSK_A : QPSK_A;
    endcase
  end

endmodule

// File: rtl/qam_mapper.sv
// Packs 32-bit words into a bit buffer and Gray-maps 2/4/6-bit groups to
// Q1.15 complex symbols. Latency: word accepted at edge E0, first symbol valid after E1.
// Backpressure: output stalls hold DAT_O/STB_O and stop pops; input ACK_O drops once the buffer cannot take a word.
// Ports: CLK_I/RST_I clock and async active-low reset
//        DAT_I/CYC_I/STB_I/WE_I/MOD_I/ACK_O  upstream word bus, mode latched at CYC_I rise
//        DAT_O {Im,Re}/CYC_O/STB_O/WE_O/ACK_I downstream symbol bus
module qam_mapper
  import ofdm_pkg::*;
#(
  parameter int DW    = 32,
  parameter int BUF_W = 64
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          STB_I,
  input  logic          WE_I,
  input  logic [1:0]    MOD_I,
  output logic          ACK_O,
  output logic [31:0]   DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I
);

  localparam logic [6:0] ACC_LIMIT = 7'(BUF_W - DW);
  localparam logic [6:0] WORD_BITS = 7'(DW);

  // Valid bits sit MSB-aligned in r_buf; everything below them is kept zero,
  // which makes the end-of-burst zero padding free.
  logic [BUF_W-1:0] r_buf;
  logic [6:0]       r_cnt;
  state_t           r_state;
  logic [1:0]       r_mod;
  logic             r_cyc_d;
  logic             r_pend;
  logic [1:0]       r_pend_mod;
  logic [31:0]      r_dat;
  logic             r_stb;

  logic [6:0]        w_n;
  logic              w_halt;
  logic              w_full_grp;
  logic              w_pop;
  logic [6:0]        w_pop_amt;
  logic              w_acc;
  logic [6:0]        w_cnt_pop;
  logic [6:0]        w_cnt_next;
  logic [BUF_W-1:0]  w_buf_next;
  logic              w_rise;
  logic [2:0]        w_i_bits;
  logic [2:0]        w_q_bits;
  logic signed [15:0] w_i_lvl;
  logic signed [15:0] w_q_lvl;

  always_comb begin
    w_n        = bits_per_sym(r_mod);
    w_halt     = r_stb & ~ACK_I;
    w_full_grp = (r_cnt >= w_n);
    // During FLUSH a short remainder is popped whole; the zero fill below it
    // supplies the padding.
    w_pop      = ~w_halt & (w_full_grp | ((r_state == ST_FLUSH) & (r_cnt != 7'd0)));
    w_pop_amt  = w_pop ? (w_full_grp ? w_n : r_cnt) : 7'd0;
    w_acc      = CYC_I & STB_I & WE_I & (r_state == ST_RUN) & (r_cnt <= ACC_LIMIT);
    w_cnt_pop  = r_cnt - w_pop_amt;
    // New word lands directly below whatever survives this cycle's pop
    w_buf_next = (r_buf << w_pop_amt)
               | (w_acc ? ({DAT_I, {(BUF_W-DW){1'b0}}} >> w_cnt_pop) : '0);
    w_cnt_next = w_cnt_pop + (w_acc ? WORD_BITS : 7'd0);
  end

  // First half of the group drives I, second half drives Q
  always_comb begin
    w_i_bits = 3'b000;
    w_q_bits = 3'b000;
    case (r_mod)
      MOD_16QAM: begin
        w_i_bits = {1'b0, r_buf[BUF_W-1 -: 2]};
        w_q_bits = {1'b0, r_buf[BUF_W-3 -: 2]};
      end
      MOD_64QAM: begin
        w_i_bits = r_buf[BUF_W-1 -: 3];
        w_q_bits = r_buf[BUF_W-4 -: 3];
      end
      default: begin
        w_i_bits = {2'b00, r_buf[BUF_W-1]};
        w_q_bits = {2'b00, r_buf[BUF_W-2]};
      end
    endcase
  end

  gray_level_lut u_lut_i (
    .i_mod   (r_mod),
    .i_bits  (w_i_bits),
    .o_level (w_i_lvl)
  );

  gray_level_lut u_lut_q (
    .i_mod   (r_mod),
    .i_bits  (w_q_bits),
    .o_level (w_q_lvl)
  );

  assign w_rise = CYC_I & ~r_cyc_d;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_buf      <= '0;
      r_cnt      <= 7'd0;
      r_state    <= ST_IDLE;
      r_mod      <= MOD_QPSK;
      r_cyc_d    <= 1'b0;
      r_pend     <= 1'b0;
      r_pend_mod <= MOD_QPSK;
      r_dat      <= 32'd0;
      r_stb      <= 1'b0;
    end else begin
      r_buf   <= w_buf_next;
      r_cnt   <= w_cnt_next;
      r_cyc_d <= CYC_I;

      if (w_pop) begin
        r_dat <= {w_q_lvl, w_i_lvl};
        r_stb <= 1'b1;
      end else if (ACK_I) begin
        r_stb <= 1'b0;
      end

      // A burst that opens before we are back in IDLE is remembered, with
      // the mode seen at its own rising edge, and started once IDLE is reached.
      if (!CYC_I) begin
        r_pend <= 1'b0;
      end else if (w_rise && (r_state != ST_IDLE)) begin
        r_pend     <= 1'b1;
        r_pend_mod <= MOD_I;
      end else if (r_state == ST_IDLE) begin
        r_pend <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_mod   <= MOD_I;
            r_state <= ST_RUN;
          end else if (r_pend && CYC_I) begin
            r_mod   <= r_pend_mod;
            r_state <= ST_RUN;
          end
        end
        ST_RUN:   if (!CYC_I) r_state <= ST_FLUSH;
        ST_FLUSH: if (r_cnt == 7'd0) r_state <= ST_CLOSE;
        ST_CLOSE: if (!w_halt) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign ACK_O = w_acc;
  assign DAT_O = r_dat;
  assign STB_O = r_stb;
  assign WE_O  = r_stb;
  assign CYC_O = (r_state != ST_IDLE);

endmodule

// File: tb/tb_qam_mapper.sv
// Self-checking bench for qam_mapper: directed and randomised bursts
// compared against a bit-queue reference model of the constellation mapping.
module tb_qam_mapper;

  logic        clk = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        CYC_I, STB_I, WE_I;
  logic [1:0]  MOD_I;
  logic        ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O;
  logic        ACK_I;

  int checks = 0;
  int errors = 0;
  bit done;

  logic [31:0] words_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  always #5 clk = ~clk;

  qam_mapper dut (
    .CLK_I (clk),
    .RST_I (RST_I),
    .DAT_I (DAT_I),
    .CYC_I (CYC_I),
    .STB_I (STB_I),
    .WE_I  (WE_I),
    .MOD_I (MOD_I),
    .ACK_O (ACK_O),
    .DAT_O (DAT_O),
    .CYC_O (CYC_O),
    .STB_O (STB_O),
    .WE_O  (WE_O),
    .ACK_I (ACK_I)
  );

  // Every output handshake completes on the next rising edge
  always @(negedge clk) if (STB_O && ACK_I) got_q.push_back(DAT_O);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] axis_level(input logic [1:0] mode, input int g, input int k);
    int bin, lvl, amp;
    if (k == 1) begin
      amp = 'h5A82;
      return 16'((g == 0) ? amp : -amp);
    end
    bin = g ^ (g >> 1) ^ (g >> 2);      // Gray -> binary
    lvl = 2 * bin - ((1 << k) - 1);     // odd levels -(M-1)..+(M-1)
    amp = (k == 2) ? 'h2AAA : 'h1249;
    return 16'(lvl * amp);
  endfunction

  function automatic void build_expected(input logic [1:0] mode);
    bit bits[$];
    int n, k, gi, gq;
    n = (mode == 2'b01) ? 4 : (mode == 2'b10) ? 6 : 2;
    k = n / 2;
    foreach (words_q[w]) for (int b = 31; b >= 0; b--) bits.push_back(words_q[w][b]);
    while (bits.size() % n != 0) bits.push_back(1'b0);
    for (int s = 0; s < bits.size() / n; s++) begin
      gi = 0; gq = 0;
      for (int j = 0; j < k; j++) begin
        gi = gi * 2 + int'(bits[s*n + j]);
        gq = gq * 2 + int'(bits[s*n + k + j]);
      end
      exp_q.push_back({axis_level(mode, gq, k), axis_level(mode, gi, k)});
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_words(input logic [1:0] mode);
    int t;
    @(posedge clk); #1;
    CYC_I = 1'b1; MOD_I = mode;
    foreach (words_q[i]) begin
      STB_I = 1'b1; WE_I = 1'b1; DAT_I = words_q[i];
      t = 0;
      do begin @(negedge clk); t++; end while (!ACK_O && t < 500);
      if (!ACK_O) begin
        checks++; errors++;
        $display("FAIL accept_timeout: word %0d not acknowledged, ACK_O=%b required 1", i, ACK_O);
      end
      @(posedge clk); #1;
      MOD_I = 2'($urandom);   // later changes must not affect the latched mode
    end
    STB_I = 1'b0; WE_I = 1'b0; CYC_I = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (CYC_O && t < 2000);
    if (CYC_O) begin
      checks++; errors++;
      $display("FAIL cyc_o_fall: CYC_O=%b required 0 at burst end", CYC_O);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; DAT_I = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++; if (DAT_O !== 32'd0) begin errors++; $display("FAIL reset_dat_o: got %h required 0", DAT_O); end
    checks++; if (STB_O !== 1'b0) begin errors++; $display("FAIL reset_stb_o: got %b required 0", STB_O); end
    checks++; if (CYC_O !== 1'b0) begin errors++; $display("FAIL reset_cyc_o: got %b required 0", CYC_O); end
    checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL reset_ack_o: got %b required 0", ACK_O); end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    @(posedge clk); #1; RST_I = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_qpsk_zero();
    words_q.delete(); words_q.push_back(32'h0); got_q.delete();
    drive_words(2'b00);
    wait_idle();
    checks++;
    if (got_q.size() != 16) begin errors++; $display("FAIL qpsk_count: got %0d required 16", got_q.size()); end
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] !== 32'h5A82_5A82) begin errors++; $display("FAIL qpsk_sym[%0d]: got %h required 5a825a82", i, got_q[i]); end
    end
  endtask

  task automatic test_latency();
    logic [31:0] w;
    w = $urandom;
    words_q.delete(); words_q.push_back(w); exp_q.delete(); got_q.delete();
    build_expected(2'b01);
    @(posedge clk); #1;
    CYC_I = 1'b1; MOD_I = 2'b01; STB_I = 1'b1; WE_I = 1'b1; DAT_I = w;
    @(negedge clk);
    checks++; if (CYC_O !== 1'b0) begin errors++; $display("FAIL lat_cyc_pre: got %b required 0", CYC_O); end
    @(posedge clk); #1; MOD_I = 2'b10;
    @(negedge clk);
    checks++; if (CYC_O !== 1'b1) begin errors++; $display("FAIL lat_cyc_rise: got %b required 1", CYC_O); end
    checks++; if (ACK_O !== 1'b1) begin errors++; $display("FAIL lat_ack_o: got %b required 1", ACK_O); end
    @(posedge clk); #1;                      // E0: word accepted
    STB_I = 1'b0; WE_I = 1'b0; CYC_I = 1'b0;
    @(negedge clk);
    checks++; if (STB_O !== 1'b0) begin errors++; $display("FAIL lat_stb_e0: got %b required 0", STB_O); end
    @(posedge clk);                          // E1: first symbol
    @(negedge clk);
    checks++; if (STB_O !== 1'b1) begin errors++; $display("FAIL lat_stb_e1: got %b required 1", STB_O); end
    checks++; if (DAT_O !== exp_q[0]) begin errors++; $display("FAIL lat_first_sym: got %h required %h", DAT_O, exp_q[0]); end
    wait_idle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL lat_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL lat_sym[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_16qam();
    words_q.delete(); words_q.push_back(32'h1234_5678); exp_q.delete(); got_q.delete();
    build_expected(2'b01);
    drive_words(2'b01);
    wait_idle();
    checks++;
    if (got_q.size() != 8) begin errors++; $display("FAIL qam16_count: got %0d required 8", got_q.size()); end
    checks++;
    if (got_q.size() > 0 && got_q[0] !== 32'hD556_8002) begin errors++; $display("FAIL qam16_first: got %h required d5568002", got_q[0]); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL qam16_sym[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_64qam_pad();
    logic [31:0] req;
    words_q.delete(); words_q.push_back(32'hFFFF_FFFF); words_q.push_back(32'hFFFF_FFFF); got_q.delete();
    drive_words(2'b10);
    wait_idle();
    checks++;
    if (got_q.size() != 11) begin errors++; $display("FAIL qam64_count: got %0d required 11", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 11; i++) begin
      req = (i == 10) ? 32'h7FFF_36DB : 32'h36DB_36DB;
      checks++;
      if (got_q[i] !== req) begin errors++; $display("FAIL qam64_sym[%0d]: got %h required %h", i, got_q[i], req); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int tw, bad;
    words_q.delete(); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 8; i++) words_q.push_back($urandom);
    build_expected(2'b10);
    fork
      begin
        drive_words(2'b10);
        wait_idle();
      end
      begin
        tw = 0;
        do begin @(negedge clk); tw++; end while (!STB_O && tw < 100);
        @(posedge clk); #1; ACK_I = 1'b0;
        @(negedge clk); held = DAT_O;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
          if (c > 0) @(negedge clk);
          if (DAT_O !== held || STB_O !== 1'b1 || WE_O !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d stall cycles changed DAT_O/STB_O/WE_O, required 0", bad); end
        checks++;
        if (ACK_O !== 1'b0) begin errors++; $display("FAIL bp_ack_full: ACK_O=%b required 0 with full buffer", ACK_O); end
        @(posedge clk); #1; ACK_I = 1'b1;
        tw = 0;
        do begin @(negedge clk); tw++; end while (!ACK_O && tw < 8);
        checks++;
        if (ACK_O !== 1'b1) begin errors++; $display("FAIL bp_ack_resume: ACK_O=%b required 1 after drain", ACK_O); end
      end
    join
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_sym[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    CYC_I = 1'b1; MOD_I = 2'b10; STB_I = 1'b1; WE_I = 1'b1; DAT_I = $urandom;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (STB_O !== 1'b1) begin errors++; $display("FAIL rst_stb_before: got %b required 1", STB_O); end
    RST_I = 1'b0; #1;
    checks++; if (DAT_O !== 32'd0) begin errors++; $display("FAIL rst_mid_dat_o: got %h required 0", DAT_O); end
    checks++; if (STB_O !== 1'b0) begin errors++; $display("FAIL rst_mid_stb_o: got %b required 0", STB_O); end
    checks++; if (CYC_O !== 1'b0) begin errors++; $display("FAIL rst_mid_cyc_o: got %b required 0", CYC_O); end
    checks++; if (ACK_O !== 1'b0) begin errors++; $display("FAIL rst_mid_ack_o: got %b required 0", ACK_O); end
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    got_q.delete();
    @(posedge clk); #1; RST_I = 1'b1;
    words_q.delete(); words_q.push_back($urandom); exp_q.delete();
    build_expected(2'b00);
    drive_words(2'b00);
    wait_idle();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_new_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rst_new_sym[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_restart_in_flush();
    logic [31:0] w2;
    int t, bad;
    words_q.delete(); exp_q.delete(); got_q.delete();
    words_q.push_back($urandom); words_q.push_back($urandom);
    build_expected(2'b10);
    w2 = $urandom;
    drive_words(2'b10);
    @(posedge clk); #1;                     // mapper now flushing
    CYC_I = 1'b1; MOD_I = 2'b01; STB_I = 1'b1; WE_I = 1'b1; DAT_I = w2;
    @(posedge clk); #1; MOD_I = 2'b00;
    t = 0; bad = 0;
    while (t < 200) begin
      @(negedge clk); t++;
      if (!CYC_O) break;
      if (ACK_O) bad++;
    end
    checks++;
    if (bad != 0 || CYC_O) begin errors++; $display("FAIL flush_no_ack: %0d early accepts, CYC_O=%b, required 0 and 0", bad, CYC_O); end
    t = 0;
    while (!ACK_O && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!ACK_O) begin errors++; $display("FAIL flush_second_ack: ACK_O=%b required 1", ACK_O); end
    @(posedge clk); #1;
    STB_I = 1'b0; WE_I = 1'b0; CYC_I = 1'b0;
    wait_idle();
    words_q.delete(); words_q.push_back(w2);
    build_expected(2'b01);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL flush_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_sym[%0d]: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    int nw;
    for (int b = 0; b < 10; b++) begin
      m  = 2'($urandom_range(0, 3));
      nw = $urandom_range(1, 5);
      words_q.delete(); exp_q.delete(); got_q.delete();
      for (int i = 0; i < nw; i++) words_q.push_back($urandom);
      build_expected(m);
      done = 1'b0;
      fork
        begin
          drive_words(m);
          wait_idle();
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk); #1;
            if (!done) ACK_I = ($urandom_range(0, 3) != 0);
          end
          ACK_I = 1'b1;
        end
      join
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: mode %0d got %0d required %0d", b, m, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_sym[%0d]: got %h required %h", b, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    DAT_I = 32'd0; MOD_I = 2'b00; ACK_I = 1'b1;
    test_reset();
    test_qpsk_zero();
    test_latency();
    test_16qam();
    test_64qam_pad();
    test_backpressure();
    test_reset_mid_run();
    test_restart_in_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
